// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: picks and formats the register-file write value,
// flags bad loads and counts retired instructions. All outputs are registered.
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            Clk_In,
    input  logic            Reset_n_In,
    input  logic            Valid_In,
    input  logic            Stall_In,
    input  logic            Flush_In,
    input  logic            Reg_Write_flag_In,
    input  logic [4:0]      RD_Addr_In,
    input  logic [1:0]      WB_Sel_In,
    input  logic [2:0]      Funct3_In,
    input  logic [XLEN-1:0] ALU_Result_In,
    input  logic [XLEN-1:0] Load_Data_In,
    input  logic [XLEN-1:0] PC_Plus4_In,
    input  logic [XLEN-1:0] Imm_In,
    output logic            Valid_Out,
    output logic            Reg_Write_flag_Out,
    output logic [4:0]      RD_Addr_Out,
    output logic [XLEN-1:0] RD_Data_Out,
    output logic            Load_Error_Out,
    output logic [XLEN-1:0] Retired_Count_Out
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic            r_valid;
    logic            r_reg_write;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_data;
    logic            r_load_error;
    logic [XLEN-1:0] r_retired_count;

    logic            w_capture;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_value;
    logic            w_funct3_bad;
    logic            w_misaligned;
    logic            w_load_error;
    logic [XLEN-1:0] w_sel_data;
    logic            w_rd_is_x0;

    assign w_capture  = Valid_In & ~Stall_In & ~Flush_In;
    assign w_rd_is_x0 = (RD_Addr_In == 5'd0);

    // Lane extraction from the aligned memory word.
    always_comb begin
        w_byte = Load_Data_In[7:0];
        case (ALU_Result_In[1:0])
            2'b00:   w_byte = Load_Data_In[7:0];
            2'b01:   w_byte = Load_Data_In[15:8];
            2'b10:   w_byte = Load_Data_In[23:16];
            default: w_byte = Load_Data_In[31:24];
        endcase
        w_half = ALU_Result_In[1] ? Load_Data_In[31:16] : Load_Data_In[15:0];
    end

    always_comb begin
        w_load_value = '0;
        w_funct3_bad = 1'b0;
        w_misaligned = 1'b0;
        case (Funct3_In)
            3'b000: w_load_value = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100: w_load_value = {{(XLEN-8){1'b0}}, w_byte};
            3'b001: begin
                w_load_value = {{(XLEN-16){w_half[15]}}, w_half};
                w_misaligned = ALU_Result_In[0];
            end
            3'b101: begin
                w_load_value = {{(XLEN-16){1'b0}}, w_half};
                w_misaligned = ALU_Result_In[0];
            end
            3'b010: begin
                w_load_value = Load_Data_In;
                w_misaligned = (ALU_Result_In[1:0] != 2'b00);
            end
            default: w_funct3_bad = 1'b1;
        endcase
    end

    assign w_load_error = (WB_Sel_In == SEL_LOAD) & (w_funct3_bad | w_misaligned);

    always_comb begin
        case (WB_Sel_In)
            SEL_ALU:  w_sel_data = ALU_Result_In;
            SEL_LOAD: w_sel_data = w_load_value;
            SEL_PC4:  w_sel_data = PC_Plus4_In;
            default:  w_sel_data = Imm_In;
        endcase
    end

    // Stall holds everything, so flush and bubbles are only honoured when unstalled.
    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_valid         <= 1'b0;
            r_reg_write     <= 1'b0;
            r_rd_addr       <= '0;
            r_rd_data       <= '0;
            r_load_error    <= 1'b0;
            r_retired_count <= '0;
        end else if (!Stall_In) begin
            if (w_capture) begin
                r_valid      <= 1'b1;
                r_reg_write  <= Reg_Write_flag_In & ~w_load_error & ~w_rd_is_x0;
                r_rd_addr    <= RD_Addr_In;
                r_rd_data    <= (w_load_error | w_rd_is_x0) ? '0 : w_sel_data;
                r_load_error <= w_load_error;
                if (!w_load_error) begin
                    r_retired_count <= r_retired_count + 1'b1;
                end
            end else begin
                r_valid      <= 1'b0;
                r_reg_write  <= 1'b0;
                r_rd_addr    <= '0;
                r_rd_data    <= '0;
                r_load_error <= 1'b0;
            end
        end
    end

    assign Valid_Out          = r_valid;
    assign Reg_Write_flag_Out = r_reg_write;
    assign RD_Addr_Out        = r_rd_addr;
    assign RD_Data_Out        = r_rd_data;
    assign Load_Error_Out     = r_load_error;
    assign Retired_Count_Out  = r_retired_count;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back selector for the RISC-V pipeline; it sits directly upstream of the register file. Each cycle it captures the instruction leaving the memory stage, selects and formats the value to be written (ALU result, sign/zero-extended load data, PC+4 or immediate), and drives the register file's write flag, destination address and write data from registered outputs. It also flags bad loads and keeps a retired-instruction counter.

## Interface
- XLEN, 32, datapath width; only 32 supported.
- Clk_In  input  1  pipeline clock, rising edge.
- Reset_n_In  input  1  asynchronous, active-low reset.
- Valid_In  input  1  MEM stage presents an instruction this cycle.
- Stall_In  input  1  hold the WB register contents.
- Flush_In  input  1  replace the incoming instruction with a bubble.
- Reg_Write_flag_In  input  1  instruction writes RD.
- RD_Addr_In  input  5  destination register.
- WB_Sel_In  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- Funct3_In  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ALU_Result_In  input  32  ALU result; for loads, the effective address.
- Load_Data_In  input  32  raw aligned word read from data memory.
- PC_Plus4_In  input  32  return address for JAL/JALR.
- Imm_In  input  32  U-type immediate (LUI).
- Valid_Out  output  1  WB register holds a live instruction.
- Reg_Write_flag_Out  output  1  write enable to the register file.
- RD_Addr_Out  output  5  write address to the register file.
- RD_Data_Out  output  32  write data to the register file.
- Load_Error_Out  output  1  captured load was misaligned or had an illegal Funct3.
- Retired_Count_Out  output  32  retired-instruction counter.

## Operation
- Capture condition is Valid_In & !Stall_In & !Flush_In. On capture, all outputs load from the combinational selection below.
- Bubble: when !Stall_In and (Flush_In or !Valid_In), load Valid_Out=0, Reg_Write_flag_Out=0, RD_Addr_Out=0, RD_Data_Out=0 and Load_Error_Out=0.
- Stall_In=1 holds every output and the counter; Flush_In is ignored while stalled (stall has priority).
- Data selection:
  - WB_Sel 00: ALU_Result_In.
  - WB_Sel 10: PC_Plus4_In.
  - WB_Sel 11: Imm_In.
  - WB_Sel 01 (load): byte lane = ALU_Result_In[1:0] and half lane = ALU_Result_In[1].
    - LB and LBU take byte Load_Data_In[8*lane+7 : 8*lane]; LB sign-extends, LBU zero-extends.
    - LH and LHU take the selected half; LH sign-extends, LHU zero-extends.
    - LW takes the full word.
- Load errors apply only when WB_Sel=01. An error is any of:
  - LH or LHU with address[0]=1;
  - LW with address[1:0]≠00;
  - Funct3 of 011, 110 or 111.
- On a load error: Load_Error_Out=1, Reg_Write_flag_Out=0, RD_Data_Out=0, Valid_Out=1, and the counter does not increment.
- x0 rule: RD_Addr_In=0 forces Reg_Write_flag_Out=0 and RD_Data_Out=0 (RD_Addr_Out=0 is still captured).
- Reg_Write_flag_Out = Reg_Write_flag_In & !error & (RD_Addr_In≠0).
- Counter: increments by 1 on every capture without a load error, whether or not the instruction writes a register; wraps from 0xFFFFFFFF to 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and stay stable for the full cycle N+1, so the register file can write during that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (asynchronous assert, synchronous release at the next edge): every output is 0, including Retired_Count_Out=0. Reset asserted mid-stall clears the held instruction immediately.
- Inputs are sampled only on rising edges; X on data inputs while Valid_In=0 must not propagate to RD_Data_Out.

## Test plan
- Reset then ALU write: Valid=1, RD=5, WB_Sel=00, ALU=0x0000_1234 -> next cycle Reg_Write_flag_Out=1, RD_Addr_Out=5, RD_Data_Out=0x1234, Retired_Count_Out=1.
- Load extension with Load_Data_In=0x80FF_7F80:
  - LB at address 0x...0 -> 0xFFFF_FF80; LBU at 0x...0 -> 0x0000_0080.
  - LH at 0x...2 -> 0xFFFF_80FF; LHU at 0x...2 -> 0x0000_80FF.
  - LW -> 0x80FF_7F80.
- Load errors: LW at 0x...2 -> Load_Error_Out=1, Reg_Write_flag_Out=0, counter unchanged; Funct3=011 gives the same response.
- Stall/flush priority: capture instruction A, then Stall=1 and Flush=1 for 3 cycles -> outputs hold A and the counter is unchanged; release with Flush=1 -> bubble captured with all-zero outputs.
- x0 and PC+4: JAL with RD=0, PC+4=0x104 -> Reg_Write_flag_Out=0, RD_Data_Out=0, counter +1; the same instruction with RD=1 -> RD_Data_Out=0x104.
- Counter wrap: preload the counter to 0xFFFF_FFFF via 2^32−1 captures or a force -> the next valid capture gives 0x0000_0000; Reset_n_In low mid-cycle clears all outputs immediately.
